// File: rtl/matriz_scan_capture.sv
// Receive side of the column-scanned LED matrix: rebuilds the five column bitmaps
// from the row lines and one-hot column strobes, publishing only complete in-order frames.
//
// state    | meaning
// EXPECT_0 | waiting for column 0 (start of frame)
// EXPECT_1 | column 0 stored, waiting for column 1
// EXPECT_2 | columns 0..1 stored, waiting for column 2
// EXPECT_3 | columns 0..2 stored, waiting for column 3
// EXPECT_4 | columns 0..3 stored, column 4 completes the frame
module matriz_scan_capture #(
    parameter int STABLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] linhas,
    input  logic [4:0] colunas,
    output logic [6:0] mapa0,
    output logic [6:0] mapa1,
    output logic [6:0] mapa2,
    output logic [6:0] mapa3,
    output logic [6:0] mapa4,
    output logic       frame_valid,
    output logic       seq_error,
    output logic [7:0] frame_count
);

    typedef enum logic [2:0] {
        EXPECT_0 = 3'd0,
        EXPECT_1 = 3'd1,
        EXPECT_2 = 3'd2,
        EXPECT_3 = 3'd3,
        EXPECT_4 = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

    state_t           state_q, state_d;
    logic [4:0]       last_col_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0][6:0]  shadow_q, shadow_d;
    logic [4:0][6:0]  mapa_q, mapa_d;
    logic             frame_valid_q, frame_valid_d;
    logic             seq_error_q, seq_error_d;
    logic [7:0]       frame_count_q, frame_count_d;

    logic       one_hot;
    logic       multi_hot;
    logic       same_col;
    logic       capture;
    logic [2:0] col_idx;

    assign one_hot   = (colunas != 5'd0) && ((colunas & (colunas - 5'd1)) == 5'd0);
    assign multi_hot = (colunas != 5'd0) && !one_hot;
    assign same_col  = (colunas == last_col_q);

    always_comb begin
        col_idx = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (colunas[i]) col_idx = 3'(i);
        end
    end

    // Capture fires only on the edge the dwell first reaches STABLE, never again while held.
    always_comb begin
        cnt_d   = '0;
        capture = 1'b0;
        if (enable && one_hot) begin
            if (same_col) cnt_d = (cnt_q >= STABLE) ? cnt_q : cnt_q + CNT_W'(1);
            else          cnt_d = CNT_W'(1);
            capture = (cnt_d == STABLE) && !(same_col && (cnt_q == STABLE));
        end
    end

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        mapa_d        = mapa_q;
        frame_valid_d = 1'b0;
        seq_error_d   = 1'b0;
        frame_count_d = frame_count_q;
        if (!enable) begin
            state_d = EXPECT_0;
        end else if (multi_hot) begin
            state_d     = EXPECT_0;
            seq_error_d = !same_col;
        end else if (capture) begin
            if (col_idx == state_q) begin
                if (state_q == EXPECT_4) begin
                    mapa_d[3:0]   = shadow_q;
                    mapa_d[4]     = linhas;
                    frame_valid_d = 1'b1;
                    frame_count_d = frame_count_q + 8'd1;
                    state_d       = EXPECT_0;
                end else begin
                    shadow_d[col_idx[1:0]] = linhas;
                    state_d                = state_t'(state_q + 3'd1);
                end
            end else if (col_idx == 3'd0) begin
                shadow_d[0] = linhas;
                state_d     = EXPECT_1;
                seq_error_d = 1'b1;
            end else begin
                state_d     = EXPECT_0;
                seq_error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= EXPECT_0;
            last_col_q    <= '0;
            cnt_q         <= '0;
            shadow_q      <= '0;
            mapa_q        <= '0;
            frame_valid_q <= 1'b0;
            seq_error_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            last_col_q    <= colunas;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            mapa_q        <= mapa_d;
            frame_valid_q <= frame_valid_d;
            seq_error_q   <= seq_error_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign mapa0       = mapa_q[0];
    assign mapa1       = mapa_q[1];
    assign mapa2       = mapa_q[2];
    assign mapa3       = mapa_q[3];
    assign mapa4       = mapa_q[4];
    assign frame_valid = frame_valid_q;
    assign seq_error   = seq_error_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_matriz_scan_capture.sv
// Bench for matriz_scan_capture: three instances (S=2,3,1) share stimulus and are
// compared every cycle against a dwell-length reference model.
module tb_matriz_scan_capture;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [6:0] linhas;
    logic [4:0] colunas;

    logic [6:0] mp [3][5];
    logic       fv [3];
    logic       se [3];
    logic [7:0] fc [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        matriz_scan_capture #(
            .STABLE_CYCLES(g == 0 ? 2 : (g == 1 ? 3 : 1)),
            .CNT_W        (4)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .enable     (enable),
            .linhas     (linhas),
            .colunas    (colunas),
            .mapa0      (mp[g][0]),
            .mapa1      (mp[g][1]),
            .mapa2      (mp[g][2]),
            .mapa3      (mp[g][3]),
            .mapa4      (mp[g][4]),
            .frame_valid(fv[g]),
            .seq_error  (se[g]),
            .frame_count(fc[g])
        );
    end

    // Reference: run = length of the current run of identical one-hot samples (unbounded).
    int         m_s   [3] = '{2, 3, 1};
    int         m_k   [3];
    int         m_run [3];
    logic [4:0] m_prev[3];
    logic [6:0] m_sh  [3][5];
    logic [6:0] m_map [3][5];
    logic       m_fv  [3];
    logic       m_se  [3];
    logic [7:0] m_fc  [3];

    task automatic model_step();
        int j;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                m_k[i] = 0; m_run[i] = 0; m_prev[i] = 5'd0;
                m_fv[i] = 1'b0; m_se[i] = 1'b0; m_fc[i] = 8'd0;
                for (int c = 0; c < 5; c++) begin m_sh[i][c] = 7'd0; m_map[i][c] = 7'd0; end
            end else begin
                m_fv[i] = 1'b0;
                m_se[i] = 1'b0;
                if (!enable) begin
                    m_run[i] = 0; m_k[i] = 0;
                end else if (colunas == 5'd0) begin
                    m_run[i] = 0;
                end else if ($countones(colunas) > 1) begin
                    if (colunas != m_prev[i]) m_se[i] = 1'b1;
                    m_k[i] = 0; m_run[i] = 0;
                end else begin
                    m_run[i] = (colunas == m_prev[i] && m_run[i] > 0) ? m_run[i] + 1 : 1;
                    if (m_run[i] == m_s[i]) begin
                        j = 0;
                        for (int c = 0; c < 5; c++) if (colunas[c]) j = c;
                        if (j == m_k[i]) begin
                            if (j == 4) begin
                                for (int c = 0; c < 4; c++) m_map[i][c] = m_sh[i][c];
                                m_map[i][4] = linhas;
                                m_fv[i] = 1'b1;
                                m_fc[i] = m_fc[i] + 8'd1;
                                m_k[i] = 0;
                            end else begin
                                m_sh[i][j] = linhas;
                                m_k[i] = m_k[i] + 1;
                            end
                        end else if (j == 0) begin
                            m_sh[i][0] = linhas; m_k[i] = 1; m_se[i] = 1'b1;
                        end else begin
                            m_k[i] = 0; m_se[i] = 1'b1;
                        end
                    end
                end
                m_prev[i] = colunas;
            end
        end
    endtask

    task automatic chk(input string tag, input int idx, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] got=%0h exp=%0h t=%0t", tag, idx, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 5; c++) chk($sformatf("mapa%0d", c), i, 8'(mp[i][c]), 8'(m_map[i][c]));
            chk("frame_valid", i, 8'(fv[i]), 8'(m_fv[i]));
            chk("seq_error", i, 8'(se[i]), 8'(m_se[i]));
            chk("frame_count", i, fc[i], m_fc[i]);
            chk("fv_se_excl", i, 8'(fv[i] & se[i]), 8'd0);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic hold(input logic [4:0] c, input logic [6:0] r, input int n, input bit rnd_rows);
        colunas = c;
        linhas  = r;
        for (int t = 0; t < n; t++) begin
            if (rnd_rows) linhas = 7'($urandom_range(0, 127));
            step();
        end
    endtask

    task automatic send_frame(input logic [6:0] rows [5], input int dwell, input int blank);
        for (int c = 0; c < 5; c++) begin
            hold(5'(1 << c), rows[c], dwell, 1'b0);
            if (blank > 0) hold(5'd0, 7'd0, blank, 1'b0);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        hold(colunas, linhas, n, 1'b0);
        reset = 1'b0;
    endtask

    logic [6:0] rows_a [5];
    logic [6:0] rows_r [5];
    logic [4:0] mh;
    int         sel;

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        linhas  = 7'd0;
        colunas = 5'd0;
        do_reset(2);
        for (int i = 0; i < 3; i++) begin
            chk("rst_fc", i, fc[i], 8'd0);
            chk("rst_mapa4", i, 8'(mp[i][4]), 8'd0);
        end
        enable = 1'b1;

        // nominal frame
        rows_a = '{7'b0000100, 7'b0001100, 7'b1000101, 7'b1110001, 7'b1000011};
        send_frame(rows_a, 10, 0);
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 5; c++) chk("t1_mapa", c, 8'(mp[i][c]), 8'(rows_a[c]));
            chk("t1_fc", i, fc[i], 8'd1);
        end

        // back-to-back frames with mapa2 changed
        rows_r = rows_a;
        rows_r[2] = 7'b0101010;
        send_frame(rows_r, 6, 0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_mapa2", i, 8'(mp[i][2]), 8'(7'b0101010));
            chk("t2_fc", i, fc[i], 8'd2);
        end

        // glitch on c1 plus blanking
        hold(5'b00001, 7'h11, 10, 1'b0);
        hold(5'd0, 7'h00, 3, 1'b0);
        hold(5'b00010, 7'h22, 2, 1'b0);
        hold(5'd0, 7'h00, 3, 1'b0);
        hold(5'b00100, 7'h33, 10, 1'b0);
        hold(5'd0, 7'h00, 3, 1'b0);

        // order violations
        hold(5'b00001, 7'h01, 4, 1'b0);
        hold(5'b00010, 7'h02, 4, 1'b0);
        hold(5'b01000, 7'h08, 4, 1'b0);
        for (int c = 0; c < 2; c++) hold(5'(1 << c), 7'($urandom_range(0, 127)), 4, 1'b0);
        for (int c = 0; c < 5; c++) hold(5'(1 << c), 7'(7'h40 | c), 4, 1'b0);

        // multi-hot hold, reset mid-frame, enable drop
        hold(5'b00101, 7'h55, 5, 1'b0);
        for (int c = 0; c < 3; c++) hold(5'(1 << c), 7'(7'h10 + c), 4, 1'b0);
        do_reset(1);
        hold(5'b00100, 7'h2a, 3, 1'b0);
        send_frame(rows_a, 4, 1);
        for (int c = 0; c < 3; c++) hold(5'(1 << c), 7'(7'h20 + c), 4, 1'b0);
        enable = 1'b0;
        hold(5'b01000, 7'h23, 4, 1'b0);
        enable = 1'b1;
        hold(5'b10000, 7'h24, 4, 1'b0);
        send_frame(rows_r, 4, 0);

        // wrap of frame_count
        do_reset(1);
        for (int f = 0; f < 256; f++) begin
            for (int c = 0; c < 5; c++) rows_r[c] = 7'($urandom_range(0, 127));
            send_frame(rows_r, 3, 0);
            if (f == 254) for (int i = 0; i < 3; i++) chk("wrap_255", i, fc[i], 8'd255);
        end
        for (int i = 0; i < 3; i++) chk("wrap_0", i, fc[i], 8'd0);

        // randomized segments
        for (int s = 0; s < 250; s++) begin
            enable = ($urandom_range(0, 15) != 0);
            reset  = ($urandom_range(0, 60) == 0);
            sel    = $urandom_range(0, 9);
            if (sel < 2) begin
                mh = 5'd0;
            end else if (sel == 2) begin
                mh = 5'($urandom_range(0, 31));
                while ($countones(mh) < 2) mh = 5'($urandom_range(0, 31));
            end else begin
                mh = 5'(1 << $urandom_range(0, 4));
            end
            hold(mh, 7'($urandom_range(0, 127)), $urandom_range(1, 5), 1'($urandom_range(0, 1)));
            reset = 1'b0;
        end
        enable = 1'b1;
        send_frame(rows_a, 5, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
